// File: rtl/uart_receiver_ctrl.sv
// UART receive sequencer for a 16x oversampled line: qualifies the start bit,
// strobes the voting and receive shift registers, and flags frame completion.
module uart_receiver_ctrl (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       baud_tick,
  input  logic       rx_enable,
  input  logic       rx_raw,
  input  logic       rx_data,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       all_zero,
  output logic       voting_shift_en,
  output logic       receive_shift_en,
  output logic       error_check,
  output logic       rx_done,
  output logic       break_detect,
  output logic       rx_busy
);

  // state | meaning
  // IDLE  | line idle, waiting for rx_raw low while enabled
  // START | start bit: checked at sample 10, then wait for sample wrap
  // DATA  | data/parity/stop bits shifted at sample 10 of each bit
  // CHECK | single cycle: frame complete, qualify errors
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] sample_cnt;
  logic [3:0] bit_cnt;
  logic [1:0] wls_lat;
  logic       pen_lat;
  logic [3:0] frame_len;
  logic       in_frame;
  logic       vote_window;
  logic       mid_bit;

  // start bit is not shifted, so the frame is data + parity + stop
  assign frame_len   = 4'd6 + {2'b00, wls_lat} + {3'b000, pen_lat};
  assign in_frame    = (state == START) || (state == DATA);
  assign vote_window = (sample_cnt >= 4'd7) && (sample_cnt <= 4'd9);
  assign mid_bit     = baud_tick && (sample_cnt == 4'd10);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      sample_cnt <= 4'd0;
      bit_cnt    <= 4'd0;
      wls_lat    <= 2'd0;
      pen_lat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sample_cnt <= 4'd0;
          bit_cnt    <= 4'd0;
          if (rx_enable && !rx_raw) begin
            state   <= START;
            wls_lat <= wls;
            pen_lat <= pen;
          end
        end
        START: begin
          if (!rx_enable) begin
            state      <= IDLE;
            sample_cnt <= 4'd0;
          end else if (baud_tick) begin
            if ((sample_cnt == 4'd10) && rx_data) begin
              state      <= IDLE;
              sample_cnt <= 4'd0;
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
              if (sample_cnt == 4'd15) begin
                state   <= DATA;
                bit_cnt <= 4'd0;
              end
            end
          end
        end
        DATA: begin
          if (!rx_enable) begin
            state      <= IDLE;
            sample_cnt <= 4'd0;
          end else if (baud_tick) begin
            sample_cnt <= sample_cnt + 4'd1;
            if (sample_cnt == 4'd10) begin
              bit_cnt <= bit_cnt + 4'd1;
              // leave as soon as the stop bit is sampled, not at its end
              if ((bit_cnt + 4'd1) == frame_len) state <= CHECK;
            end
          end
        end
        CHECK: begin
          state      <= IDLE;
          sample_cnt <= 4'd0;
        end
        default: begin
          state      <= IDLE;
          sample_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign voting_shift_en  = baud_tick && in_frame && vote_window;
  assign receive_shift_en = mid_bit && (state == DATA);
  assign error_check      = (state == CHECK);
  assign rx_done          = (state == CHECK);
  assign break_detect     = rx_done && all_zero;
  assign rx_busy          = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver_ctrl.sv
// Randomized bench for uart_receiver_ctrl: the driver derives expected strobes
// from tick positions within each frame; a negedge monitor checks them in order.
module tb_uart_receiver_ctrl;

  logic       pclk;
  logic       presetn;
  logic       baud_tick;
  logic       rx_enable;
  logic       rx_raw;
  logic       rx_data;
  logic [1:0] wls;
  logic       pen;
  logic       all_zero;
  logic       voting_shift_en;
  logic       receive_shift_en;
  logic       error_check;
  logic       rx_done;
  logic       break_detect;
  logic       rx_busy;

  uart_receiver_ctrl dut (
    .pclk             (pclk),
    .presetn          (presetn),
    .baud_tick        (baud_tick),
    .rx_enable        (rx_enable),
    .rx_raw           (rx_raw),
    .rx_data          (rx_data),
    .wls              (wls),
    .pen              (pen),
    .all_zero         (all_zero),
    .voting_shift_en  (voting_shift_en),
    .receive_shift_en (receive_shift_en),
    .error_check      (error_check),
    .rx_done          (rx_done),
    .break_detect     (break_detect),
    .rx_busy          (rx_busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // observed vector: {voting, receive_shift, rx_done, error_check, break}
  typedef struct packed {
    int         cyc;
    logic [4:0] obs;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic next_cycle();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_line(input logic v);
    rx_raw  = v;
    rx_data = v;
  endtask

  task automatic push_ev(input int c, input logic [4:0] o);
    ev_t e;
    e.cyc = c;
    e.obs = o;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: cycle %0d got %b expected %b", name, cyc, act, want);
    end
  endtask

  always @(negedge pclk) begin : monitor
    ev_t        e;
    logic [4:0] obs;
    obs = {voting_shift_en, receive_shift_en, rx_done, error_check, break_detect};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_event: cycle %0d got nothing expected %b", e.cyc, e.obs);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.obs) begin
        failures++;
        $display("FAIL strobe_event: cycle %0d got %b expected %b", cyc, obs, e.obs);
      end
    end else if (obs !== 5'b00000) begin
      checks++;
      failures++;
      $display("FAIL unexpected_strobe: cycle %0d got %b expected 00000", cyc, obs);
    end
  end

  // kind: 0 normal frame, 1 false start, 2 reset at sample 5 of bit 3
  task automatic run_frame(input int kind, input logic [1:0] w, input logic p,
                           input logic [9:0] payload, input logic stop,
                           input int abort_k, input bit cont, input bit force_az);
    int   n;
    int   j;
    int   k;
    bit   tk;
    bit   fin;
    logic ln;
    logic bits [0:10];
    n = 6 + int'(w) + int'(p);
    bits[0] = 1'b0;
    for (int i = 1; i <= 10; i++) bits[i] = (i < n) ? payload[i-1] : stop;

    next_cycle();
    rx_enable = 1'b1;
    wls = w;
    pen = p;
    drive_line(1'b0);
    baud_tick = 1'($urandom);
    all_zero = force_az ? 1'b1 : 1'($urandom);
    next_cycle();
    chk("busy_after_start", rx_busy, 1'b1);

    j = 0;
    fin = 0;
    while (!fin) begin
      wls = 2'($urandom);
      pen = 1'($urandom);
      all_zero = force_az ? 1'b1 : 1'($urandom);
      ln = (kind == 1) ? (j >= 4) : bits[j / 16];
      drive_line(ln);
      tk = cont || ($urandom_range(0, 2) == 0);
      baud_tick = tk;
      if (tk) begin
        k = j / 16;
        if ((j % 16) >= 7 && (j % 16) <= 9) push_ev(cyc, 5'b10000);
        if (j == 10 && ln) begin
          next_cycle();
          baud_tick = 1'($urandom);
          chk("busy_after_false_start", rx_busy, 1'b0);
          fin = 1;
        end else if ((j % 16) == 10 && k >= 1) begin
          push_ev(cyc, 5'b01000);
          if (k == n) begin
            next_cycle();
            drive_line(1'b1);
            baud_tick = 1'($urandom);
            all_zero = force_az ? 1'b1 : 1'($urandom);
            push_ev(cyc, {4'b0011, all_zero});
            next_cycle();
            chk("busy_after_done", rx_busy, 1'b0);
            fin = 1;
          end else if (k == abort_k) begin
            next_cycle();
            rx_enable = 1'b0;
            baud_tick = 1'b0;
            next_cycle();
            chk("busy_after_abort", rx_busy, 1'b0);
            rx_enable = 1'b1;
            drive_line(1'b1);
            fin = 1;
          end
        end else if (kind == 2 && j == 53) begin
          next_cycle();
          baud_tick = 1'b1;
          #1 presetn = 1'b0;
          #1;
          chk("rst_voting", voting_shift_en, 1'b0);
          chk("rst_receive", receive_shift_en, 1'b0);
          chk("rst_error_check", error_check, 1'b0);
          chk("rst_rx_done", rx_done, 1'b0);
          chk("rst_break", break_detect, 1'b0);
          chk("rst_busy", rx_busy, 1'b0);
          repeat (2) begin
            next_cycle();
            baud_tick = 1'($urandom);
            wls = ~w;
            drive_line(1'($urandom));
          end
          drive_line(1'b1);
          #1 presetn = 1'b1;
          next_cycle();
          chk("busy_after_reset_release", rx_busy, 1'b0);
          fin = 1;
        end
        j++;
      end
      if (!fin) next_cycle();
    end
  endtask

  task automatic idle_gap();
    int g;
    g = $urandom_range(1, 6);
    for (int i = 0; i < g; i++) begin
      rx_enable = 1'($urandom);
      drive_line(rx_enable ? 1'b1 : 1'($urandom));
      baud_tick = 1'($urandom);
      all_zero = 1'($urandom);
      wls = 2'($urandom);
      pen = 1'($urandom);
      next_cycle();
      chk("busy_idle", rx_busy, 1'b0);
    end
    rx_enable = 1'b1;
    drive_line(1'b1);
  endtask

  initial begin : watchdog
    #900000;
    failures++;
    $display("FAIL timeout: cycle %0d got no end of run expected completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    int sel;
    int kind;
    int abort_k;
    presetn = 1'b0;
    baud_tick = 1'b1;
    rx_enable = 1'b1;
    rx_raw = 1'b0;
    rx_data = 1'b0;
    wls = 2'd3;
    pen = 1'b1;
    all_zero = 1'b1;
    #3;
    chk("reset_voting", voting_shift_en, 1'b0);
    chk("reset_receive", receive_shift_en, 1'b0);
    chk("reset_error_check", error_check, 1'b0);
    chk("reset_rx_done", rx_done, 1'b0);
    chk("reset_break", break_detect, 1'b0);
    chk("reset_busy", rx_busy, 1'b0);
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_hold_busy", rx_busy, 1'b0);
    drive_line(1'b1);
    baud_tick = 1'b0;
    #1 presetn = 1'b1;
    next_cycle();
    chk("idle_after_reset", rx_busy, 1'b0);

    run_frame(0, 2'd3, 1'b0, 10'h055, 1'b1, 0, 1'b0, 1'b0);
    idle_gap();
    run_frame(0, 2'd0, 1'b1, 10'($urandom), 1'b1, 0, 1'b0, 1'b0);
    idle_gap();
    run_frame(1, 2'd2, 1'b1, 10'h3ff, 1'b1, 0, 1'b0, 1'b0);
    idle_gap();
    run_frame(0, 2'd3, 1'b1, 10'h000, 1'b0, 0, 1'b0, 1'b1);
    idle_gap();
    run_frame(0, 2'd1, 1'b0, 10'($urandom), 1'b1, 3, 1'b0, 1'b0);
    idle_gap();
    run_frame(0, 2'd1, 1'b0, 10'($urandom), 1'b1, 0, 1'b1, 1'b0);
    idle_gap();
    run_frame(2, 2'd2, 1'b0, 10'($urandom), 1'b1, 0, 1'b0, 1'b0);
    idle_gap();
    run_frame(0, 2'd0, 1'b0, 10'($urandom), 1'b1, 0, 1'b0, 1'b0);
    idle_gap();

    for (int f = 0; f < 24; f++) begin
      sel = $urandom_range(0, 9);
      kind = (sel == 0) ? 1 : (sel == 1) ? 2 : 0;
      abort_k = (sel == 2) ? $urandom_range(1, 5) : 0;
      run_frame(kind, 2'($urandom), 1'($urandom), 10'($urandom),
                ($urandom_range(0, 3) != 0), abort_k,
                ($urandom_range(0, 3) == 0), (sel == 3));
      idle_gap();
    end

    repeat (4) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events: got %0d left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
